// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Define EX_STAGE_MUL_EN to build the iterative 32-cycle unsigned multiplier (MUL/MULHU).
module ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        bubble_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [31:0] immediate,
   input  logic [3:0]  alu_ctrl,
   input  logic [4:0]  rd,
   input  logic [10:0] datapath,
   input  logic [1:0]  fwd_a_sel,
   input  logic [1:0]  fwd_b_sel,
   input  logic [31:0] wb_val,
   output logic [31:0] alu_result_out,
   output logic [31:0] store_data_out,
   output logic [4:0]  rd_out,
   output logic [31:0] pc_out,
   output logic [10:0] datapath_out,
   output logic        valid_out,
   output logic        stall_req
);

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [10:0] dp;
      logic        vld;
   } exmem_t;

   exmem_t      q, d, mul_entry;
   logic [31:0] op_a, op_bf, op_b, alu_res;
   logic        mul_done, mul_hold;

   always_comb begin
      case (fwd_a_sel)
         2'd1:    op_a = q.res;
         2'd2:    op_a = wb_val;
         default: op_a = rs1_val;
      endcase
      case (fwd_b_sel)
         2'd1:    op_bf = q.res;
         2'd2:    op_bf = wb_val;
         default: op_bf = rs2_val;
      endcase
      op_b = datapath[0] ? immediate : op_bf;
   end

   always_comb begin
      case (alu_ctrl)
         4'd0:    alu_res = op_a + op_b;
         4'd1:    alu_res = op_a - op_b;
         4'd2:    alu_res = op_a << op_b[4:0];
         4'd3:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         4'd4:    alu_res = {31'b0, op_a < op_b};
         4'd5:    alu_res = op_a ^ op_b;
         4'd6:    alu_res = op_a >> op_b[4:0];
         4'd7:    alu_res = $signed(op_a) >>> op_b[4:0];
         4'd8:    alu_res = op_a | op_b;
         4'd9:    alu_res = op_a & op_b;
         4'd10:   alu_res = op_b;
         default: alu_res = 32'd0;
      endcase
   end

`ifdef EX_STAGE_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mstate_t;
   mstate_t     st, st_nxt;
   logic [31:0] m_a, m_b, m_bf, m_pc;
   logic [4:0]  m_rd, m_cnt;
   logic [10:0] m_dp;
   logic        m_hi, issue;
   logic [63:0] m_acc;

   assign issue = (st == S_IDLE) && !bubble_in && datapath[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= S_IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      if (flush) st_nxt = S_IDLE;
      else begin
         case (st)
            S_IDLE:  if (issue) st_nxt = S_BUSY;
            S_BUSY:  if (m_cnt == 5'd31) st_nxt = S_DONE;
            S_DONE:  st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
         endcase
      end
   end

   // stall is gated by reset so a held multiply on the inputs cannot stall during reset
   always_comb begin
      stall_req = rst_n && (issue || (st == S_BUSY));
      mul_hold  = issue || (st == S_BUSY);
      mul_done  = (st == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_a <= '0; m_b <= '0; m_bf <= '0; m_pc <= '0;
         m_rd <= '0; m_dp <= '0; m_hi <= 1'b0;
         m_acc <= '0; m_cnt <= '0;
      end else if (issue) begin
         m_a <= op_a; m_b <= op_b; m_bf <= op_bf; m_pc <= pc_in;
         m_rd <= rd; m_dp <= datapath; m_hi <= alu_ctrl[0];
         m_acc <= '0; m_cnt <= '0;
      end else if (st == S_BUSY) begin
         m_acc <= m_acc + (m_b[m_cnt] ? ({32'b0, m_a} << m_cnt) : 64'd0);
         m_cnt <= m_cnt + 5'd1;
      end
   end

   always_comb begin
      mul_entry     = '0;
      mul_entry.res = m_hi ? m_acc[63:32] : m_acc[31:0];
      mul_entry.sd  = m_bf;
      mul_entry.rd  = m_rd;
      mul_entry.pc  = m_pc;
      mul_entry.dp  = m_dp;
      mul_entry.vld = 1'b1;
   end
`else
   assign stall_req = 1'b0;
   assign mul_hold  = 1'b0;
   assign mul_done  = 1'b0;
   assign mul_entry = '0;
`endif

   always_comb begin
      d = '0;
      if (flush)                      d = '0;
      else if (mul_done)              d = mul_entry;
      else if (bubble_in || mul_hold) d = '0;
      else begin
         d.res = alu_res;
         d.sd  = op_bf;
         d.rd  = rd;
         d.pc  = pc_in;
         d.dp  = datapath;
         d.vld = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= d;
   end

   assign alu_result_out = q.res;
   assign store_data_out = q.sd;
   assign rd_out         = q.rd;
   assign pc_out         = q.pc;
   assign datapath_out   = q.dp;
   assign valid_out      = q.vld;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32 pipeline. It consumes the ID/EX register outputs and resolves operand forwarding. It computes the ALU result and registers the result with its control metadata into the EX/MEM boundary. An optional iterative 32-cycle multiplier holds the pipeline through `stall_req`, which drives the ID/EX and upstream stall inputs.

## Interface
Parameters:
- none (fixed 32-bit datapath)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous kill of the in-flight EX work and of the next EX/MEM entry
- `bubble_in`  in  1  ID/EX holds no valid instruction
- `pc_in`  in  32  instruction PC
- `rs1_val`, `rs2_val`  in  32 each  register-file operands
- `immediate`  in  32  decoded immediate
- `alu_ctrl`  in  4  operation select
- `rd`  in  5  destination register
- `datapath`  in  11  control bundle
  - bit0: alu_src_imm
  - bit1: muldiv
  - bits 10:2 pass through untouched
- `fwd_a_sel`, `fwd_b_sel`  in  2 each  forwarding select
  - 0: register value
  - 1: `alu_result_out`
  - 2: `wb_val`
  - 3: register value
- `wb_val`  in  32  MEM/WB writeback value
- `alu_result_out`  out  32  registered result
- `store_data_out`  out  32  registered forwarded rs2
- `rd_out`  out  5  registered destination register
- `pc_out`  out  32  registered PC
- `datapath_out`  out  11  registered control bundle
- `valid_out`  out  1  EX/MEM entry is a real instruction
- `stall_req`  out  1  combinational; hold ID/EX and earlier stages

## Operation
Operand selection:
- A = forwarded rs1.
- Bf = forwarded rs2.
- B = alu_src_imm ? `immediate` : Bf.

ALU ops, selected by `alu_ctrl`:
- 0 ADD
- 1 SUB
- 2 SLL
- 3 SLT (signed)
- 4 SLTU
- 5 XOR
- 6 SRL
- 7 SRA
- 8 OR
- 9 AND
- 10 PASS B
- 11-15 result 0

Arithmetic rules: shifts use B[4:0], and all arithmetic wraps modulo 2^32.

Multiplier FSM (`MUL_EN` only) has three states: IDLE, BUSY, DONE.
- **IDLE:**
  - A valid instruction (`bubble_in`=0, muldiv=1) raises `stall_req` combinationally.
  - On the edge it latches A, B, `rd`, `pc_in`, `datapath`, `alu_ctrl` and Bf, clears the 64-bit accumulator and the 5-bit count, and moves to BUSY.
- **BUSY:** one unsigned shift-add step per cycle. `stall_req`=1. Inputs, including `bubble_in`, are ignored. After the step with count=31 the FSM moves to DONE.
- **DONE:** `stall_req`=0. On the edge the EX/MEM register loads from the latched metadata:
  - product[31:0] when latched `alu_ctrl[0]`=0 (MUL)
  - product[63:32] when latched `alu_ctrl[0]`=1 (MULHU)
  - `valid_out`=1
  - the FSM returns to IDLE

EX/MEM register load, per edge, in priority order:
1. `flush`: all outputs to 0 and FSM to IDLE; this aborts any multiply.
2. DONE: product as above.
3. IDLE with `bubble_in`=1: all outputs to 0.
4. IDLE with a non-mul valid instruction: ALU result, Bf, `rd`, `pc_in`, `datapath`, `valid_out`=1.
5. IDLE issuing a multiply, or BUSY: `valid_out`=0 and `datapath_out`=0, which inserts a bubble downstream.

## Timing
- Reset (`rst_n`=0, asynchronous): every output is 0, the FSM is IDLE, the count and accumulator are 0. `stall_req` is 0 during reset. Reset mid-multiply discards the operation.
- ALU instructions: 1-cycle latency, with the result visible after the edge that samples the inputs.
- Multiply:
  - `stall_req` is high for exactly 33 cycles: the issue cycle plus 32 BUSY cycles.
  - The result is registered at the 34th edge after first presentation.
  - The next instruction enters EX in the cycle after DONE.
- `stall_req` while in DONE is 0 even though the held multiply is still on the inputs; the FSM does not re-issue from DONE.
- `flush` together with a new multiply in IDLE: flush wins and no multiply starts.
- Forwarding select 1 uses the current registered `alu_result_out`, meaning the value from the previous cycle.

## Configuration
- `EX_STAGE_MUL_EN` defined:
  - the multiplier FSM, accumulator and counter are built
  - `stall_req` behaves as above
- Not defined:
  - datapath bit1 is ignored, so muldiv instructions execute as the ALU op given by `alu_ctrl`
  - `stall_req` is tied to 0
  - no FSM logic is built

## Test plan
- ADDI: `rs1_val`=0x10, `immediate`=0xFFFFFFFF, alu_src_imm=1, `alu_ctrl`=0 → next edge `alu_result_out`=0x0000000F, `valid_out`=1, `rd_out` = input `rd`.
- Forwarding:
  - SUB with `fwd_a_sel`=1 after ADD producing 5, and `rs2_val`=7 → 0xFFFFFFFE.
  - `fwd_b_sel`=2 with `wb_val`=3 → B=3.
  - SRA with A=0x80000000, B=4 → 0xF8000000.
- MUL/MULHU with A=0xFFFFFFFF, B=2:
  - `stall_req` high for exactly 33 cycles
  - 34th edge gives `alu_result_out`=0xFFFFFFFE for MUL and 0x00000001 for MULHU
  - `valid_out` is 0 during BUSY
- Bubble: `bubble_in`=1 with arbitrary operands → all outputs 0 next edge; `stall_req` stays 0 even with muldiv=1.
- Flush and reset:
  - `flush` pulsed at BUSY count=10 → `stall_req` drops the same cycle after that edge, outputs 0, a subsequent ALU op completes normally.
  - `rst_n` low mid-BUSY → immediate zero outputs and IDLE.
- Without `EX_STAGE_MUL_EN`: muldiv=1, `alu_ctrl`=0, A=3, B=4 → 1-cycle result 7, `stall_req` never asserts.
